// File: rtl/bcd_count_ctrl.sv
// Controller for a 3-digit BCD counter chain: prescaled count pulses, clears, terminal-count compare, start/stop/clear FSM.
// cnt_cin/done/cnt_rst_n are registered 1 cycle after the decision; no backpressure; BCD_CTRL_LIMIT_CHECK_EN adds limit_err.
module bcd_count_ctrl #(
    parameter int DIV = 4,
    parameter int PW  = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        cmd_start,
    input  logic        cmd_stop,
    input  logic        cmd_clear,
    input  logic        auto_reload,
    input  logic [11:0] limit,
    input  logic [11:0] q_in,
    output logic        cnt_cin,
    output logic        cnt_rst_n,
    output logic        running,
    output logic        done,
`ifdef BCD_CTRL_LIMIT_CHECK_EN
    output logic        limit_err,
`endif
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [11:0]   limit_q, limit_d;
    logic          cin_q, cin_d;
    logic          rst_n_q, rst_n_d;
    logic          done_q, done_d;
    logic          go;
    logic          tick;
    logic          limit_bad;

    // stop outranks start, so a start only counts when stop is low
    assign go   = cmd_start & ~cmd_stop;
    assign tick = (presc_q == PRESC_LAST);

`ifdef BCD_CTRL_LIMIT_CHECK_EN
    assign limit_bad = (limit[3:0] > 4'd9) | (limit[7:4] > 4'd9) | (limit[11:8] > 4'd9);
`else
    assign limit_bad = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        limit_d = limit_q;
        cin_d   = 1'b0;
        rst_n_d = 1'b1;
        done_d  = 1'b0;
        if (cmd_clear) begin
            state_d = S_IDLE;
            presc_d = '0;
            rst_n_d = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (go && !limit_bad) begin
                        limit_d = limit;
                        presc_d = '0;
                        state_d = S_RUN;
                    end
                end
                S_RUN: begin
                    if (cmd_stop) begin
                        state_d = S_PAUSE;
                    end else if (tick) begin
                        presc_d = '0;
                        if (q_in != limit_q) begin
                            cin_d = 1'b1;
                        end else begin
                            done_d = 1'b1;
                            if (auto_reload) rst_n_d = 1'b0;
                            else             state_d = S_DONE;
                        end
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                S_PAUSE: begin
                    if (go) state_d = S_RUN;
                end
                default: begin
                    if (go) begin
                        if (limit_bad) begin
                            state_d = S_IDLE;
                        end else begin
                            rst_n_d = 1'b0;
                            limit_d = limit;
                            presc_d = '0;
                            state_d = S_RUN;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            limit_q <= '0;
            cin_q   <= 1'b0;
            rst_n_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            limit_q <= limit_d;
            cin_q   <= cin_d;
            rst_n_q <= rst_n_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_CTRL_LIMIT_CHECK_EN
    logic err_q;

    always_ff @(posedge Clk) begin
        if (Rst || cmd_clear) begin
            err_q <= 1'b0;
        end else if (go && (state_q == S_IDLE || state_q == S_DONE)) begin
            err_q <= limit_bad;
        end
    end

    assign limit_err = err_q;
`endif

    assign cnt_cin   = cin_q;
    assign cnt_rst_n = rst_n_q;
    assign done      = done_q;
    assign running   = (state_q == S_RUN);
    assign busy      = (state_q == S_RUN) || (state_q == S_PAUSE);

endmodule

// File: tb/tb_bcd_count_ctrl.sv
// Bench for bcd_count_ctrl: behavioural controller model plus a BCD counter chain, with directed scenarios.
module tb_bcd_count_ctrl;

    localparam int DIV = 4;
    localparam int PW  = 8;
`ifdef BCD_CTRL_LIMIT_CHECK_EN
    localparam bit LIM_CHK = 1'b1;
`else
    localparam bit LIM_CHK = 1'b0;
`endif
    localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

    logic        Clk;
    logic        Rst;
    logic        cmd_start, cmd_stop, cmd_clear, auto_reload;
    logic [11:0] limit;
    logic [11:0] q_in;
    logic        cnt_cin, cnt_rst_n, running, done, busy;
    logic        lerr;

    bcd_count_ctrl #(.DIV(DIV), .PW(PW)) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .cmd_start  (cmd_start),
        .cmd_stop   (cmd_stop),
        .cmd_clear  (cmd_clear),
        .auto_reload(auto_reload),
        .limit      (limit),
        .q_in       (q_in),
        .cnt_cin    (cnt_cin),
        .cnt_rst_n  (cnt_rst_n),
        .running    (running),
        .done       (done),
`ifdef BCD_CTRL_LIMIT_CHECK_EN
        .limit_err  (lerr),
`endif
        .busy       (busy)
    );
`ifndef BCD_CTRL_LIMIT_CHECK_EN
    assign lerr = 1'b0;
`endif

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // counter chain held as a plain decimal integer
    int chain;
    always @(posedge Clk) begin
        if (!cnt_rst_n)   chain <= 0;
        else if (cnt_cin) chain <= (chain == 999) ? 0 : chain + 1;
    end
    assign q_in = {4'(chain / 100), 4'((chain / 10) % 10), 4'(chain % 10)};

    function automatic bit is_bcd(input logic [11:0] v);
        for (int i = 0; i < 3; i++)
            if (((v >> (4 * i)) & 12'hF) > 12'd9) return 1'b0;
        return 1'b1;
    endfunction

    // controller model: mode plus "run cycles left before the next tick"
    int          m_mode;
    int          m_left;
    logic [11:0] m_lim;
    bit          e_cin, e_rstn, e_done, e_err, m_go;

    initial begin
        m_mode = M_IDLE; m_left = DIV; m_lim = '0;
        forever begin
            @(posedge Clk);
            m_go   = cmd_start && !cmd_stop;
            e_cin  = 1'b0;
            e_done = 1'b0;
            e_rstn = 1'b1;
            if (Rst) begin
                m_mode = M_IDLE; m_left = DIV; m_lim = '0; e_rstn = 1'b0; e_err = 1'b0;
            end else if (cmd_clear) begin
                m_mode = M_IDLE; m_left = DIV; e_rstn = 1'b0; e_err = 1'b0;
            end else if (m_mode == M_IDLE || m_mode == M_DONE) begin
                if (m_go) begin
                    if (LIM_CHK && !is_bcd(limit)) begin
                        e_err = 1'b1; m_mode = M_IDLE;
                    end else begin
                        if (m_mode == M_DONE) e_rstn = 1'b0;
                        e_err = 1'b0; m_lim = limit; m_left = DIV; m_mode = M_RUN;
                    end
                end
            end else if (m_mode == M_PAUSE) begin
                if (m_go) m_mode = M_RUN;
            end else begin
                if (cmd_stop) m_mode = M_PAUSE;
                else if (m_left > 1) m_left--;
                else begin
                    m_left = DIV;
                    if (q_in == m_lim) begin
                        e_done = 1'b1;
                        if (auto_reload) e_rstn = 1'b0;
                        else m_mode = M_DONE;
                    end else begin
                        e_cin = 1'b1;
                    end
                end
            end
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int cin_cnt = 0, done_cnt = 0, cin_last = 0, cin_prev = 0;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // one clock: per-cycle model compare at the falling edge, then pulse bookkeeping
    task automatic step();
        @(negedge Clk);
        cyc++;
        check($sformatf("cycle%0d {cin,rst_n,run,done,busy,err}", cyc),
              int'({cnt_cin, cnt_rst_n, running, done, busy, lerr}),
              int'({e_cin, e_rstn, (m_mode == M_RUN), e_done,
                    (m_mode == M_RUN || m_mode == M_PAUSE), e_err}));
        if (cnt_cin) begin cin_cnt++; cin_prev = cin_last; cin_last = cyc; end
        if (done) done_cnt++;
        #1;
    endtask

    task automatic pulse_start();
        cmd_start = 1'b1; step(); cmd_start = 1'b0;
    endtask

    task automatic do_clear();
        cmd_clear = 1'b1; step(); cmd_clear = 1'b0; step();
    endtask

    task automatic wait_q(input logic [11:0] v, input int budget);
        int n = 0;
        while (q_in != v && n < budget) begin step(); n++; end
        check($sformatf("wait_q_%0h_timeout", v), int'(q_in), int'(v));
    endtask

    task automatic wait_done(input int d0, input int budget);
        int n = 0;
        while (done_cnt == d0 && n < budget) begin step(); n++; end
        check("wait_done_timeout", int'(done_cnt != d0), 1);
    endtask

    int c0, d0, n;

    initial begin
        Rst = 1'b1; cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0;
        auto_reload = 1'b0; limit = '0;
        repeat (3) step();
        check("reset_outputs", int'({cnt_cin, cnt_rst_n, running, done, busy}), 0);
        check("reset_chain", int'(q_in), 0);
        Rst = 1'b0;
        step();
        check("idle_rst_n", int'(cnt_rst_n), 1);

        // one-shot count to 005
        limit = 12'h005; auto_reload = 1'b0;
        c0 = cin_cnt; d0 = done_cnt;
        pulse_start();
        wait_done(d0, 100);
        check("t1_cin_pulses", cin_cnt - c0, 5);
        check("t1_done_pulses", done_cnt - d0, 1);
        check("t1_q_at_limit", int'(q_in), 12'h005);
        check("t1_tick_period", cin_last - cin_prev, 4);
        step();
        check("t1_stopped", int'({running, busy}), 0);
        repeat (5) step();
        check("t1_held", int'(q_in), 12'h005);

        // start from DONE issues a one-cycle clear
        limit = 12'h002;
        pulse_start();
        check("done_restart_clear", int'({cnt_rst_n, running}), 2'b01);
        step();
        check("done_restart_q", int'({q_in, cnt_rst_n}), 13'h0001);
        do_clear();

        // auto-reload at 003, ten ticks
        limit = 12'h003; auto_reload = 1'b1;
        c0 = cin_cnt; d0 = done_cnt;
        pulse_start();
        repeat (42) step();
        check("t2_cin_pulses", cin_cnt - c0, 8);
        check("t2_done_pulses", done_cnt - d0, 2);
        check("t2_q", int'(q_in), 12'h002);
        check("t2_running", int'(running), 1);
        auto_reload = 1'b0;
        do_clear();

        // pause at 002, change limit port meanwhile, resume
        limit = 12'h009;
        d0 = done_cnt;
        pulse_start();
        wait_q(12'h002, 50);
        cmd_stop = 1'b1;
        c0 = cin_cnt;
        repeat (10) step();
        limit = 12'h001;
        repeat (10) step();
        check("t3_pause_no_cin", cin_cnt - c0, 0);
        check("t3_pause_q", int'(q_in), 12'h002);
        check("t3_pause_flags", int'({running, busy}), 2'b01);
        cmd_stop = 1'b0;
        cmd_start = 1'b1; step(); cmd_start = 1'b0;
        n = 1;
        while (cin_cnt == c0 && n < 20) begin step(); n++; end
        check("t3_resume_latency", n, 4);
        wait_done(d0, 100);
        check("t3_limit_kept", int'(q_in), 12'h009);
        do_clear();

        // clear coincident with the tick at 007
        limit = 12'h099;
        pulse_start();
        wait_q(12'h007, 60);
        step(); step();
        c0 = cin_cnt; d0 = done_cnt;
        cmd_clear = 1'b1;
        step();
        check("t4_clear_cycle", int'({cnt_cin, done, cnt_rst_n, running}), 0);
        cmd_clear = 1'b0;
        step();
        check("t4_after_clear", int'({q_in, cnt_rst_n, busy}), 14'h0002);
        check("t4_no_pulses", (cin_cnt - c0) + (done_cnt - d0), 0);

        // reset while running at 045
        pulse_start();
        wait_q(12'h045, 300);
        d0 = done_cnt;
        Rst = 1'b1;
        step();
        check("t5_reset_outputs", int'({cnt_cin, cnt_rst_n, running, done, busy}), 0);
        step(); step();
        check("t5_chain_cleared", int'({q_in, cnt_rst_n}), 0);
        Rst = 1'b0;
        step();
        check("t5_released", int'({cnt_rst_n, running, done_cnt - d0 == 0}), 3'b101);

        // non-BCD limit 0A1
        limit = 12'h0A1;
        c0 = cin_cnt; d0 = done_cnt;
        pulse_start();
`ifdef BCD_CTRL_LIMIT_CHECK_EN
        check("t6_rejected", int'({lerr, running, busy}), 3'b100);
        repeat (10) step();
        check("t6_no_count", cin_cnt - c0, 0);
        check("t6_no_clear", int'(cnt_rst_n), 1);
        limit = 12'h010;
        c0 = cin_cnt;
        pulse_start();
        check("t6_accepted", int'({lerr, running}), 2'b01);
        repeat (5) step();
        check("t6_counting", cin_cnt - c0, 1);
`else
        check("t6_started", int'(running), 1);
        repeat (130) step();
        check("t6_never_matched", done_cnt - d0, 0);
        check("t6_cin_pulses", cin_cnt - c0, 32);
        check("t6_still_running", int'(running), 1);
`endif
        do_clear();

        // limit 000 with reload: done every tick, never a count pulse
        limit = 12'h000; auto_reload = 1'b1;
        c0 = cin_cnt; d0 = done_cnt;
        pulse_start();
        repeat (20) step();
        check("t7_no_cin", cin_cnt - c0, 0);
        check("t7_done_pulses", done_cnt - d0, 5);
        auto_reload = 1'b0;
        do_clear();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bcd_count_ctrl.md
Name: bcd_count_ctrl

Overview:
- Sequencing controller for the 3-digit cascaded BCD counter chain (12-bit packed BCD value {hundreds, tens, units}).
- Generates prescaled single-cycle count-enable pulses into the chain's carry input and issues clear (reset) pulses to the chain.
- Reads back the chain's BCD value, compares it against a programmable BCD terminal count, and runs a start/stop/clear command FSM with one-shot or auto-reload modes.

Parameters:
- DIV, 4, Clk cycles per count tick while running. Legal range is DIV >= 2, which guarantees the read-back value has settled before the next compare.
- PW, 8, prescaler width in bits. Must satisfy 2^PW > DIV.

Ports:
- Clk  in  1  system clock.
- Rst  in  1  synchronous, active-high reset.
- cmd_start  in  1  start, or resume from PAUSE. Level is sampled each cycle.
- cmd_stop  in  1  pause counting.
- cmd_clear  in  1  clear the counter chain and return to IDLE.
- auto_reload  in  1  1 = wrap to 000 at the limit and keep running; 0 = stop at the limit.
- limit  in  12  BCD terminal count. Captured on the IDLE->RUN transition.
- q_in  in  12  BCD value read back from the counter chain.
- cnt_cin  out  1  registered one-cycle count-enable pulse to the chain's carry input.
- cnt_rst_n  out  1  registered active-low clear to the chain.
- running  out  1  high in RUN.
- done  out  1  one-cycle pulse when the count reaches the limit.
- busy  out  1  high in RUN or PAUSE.

Behaviour:
- Reset (Rst=1 at a rising edge):
  - state=IDLE, prescaler=0, limit_r=000.
  - cnt_cin=0, cnt_rst_n=0 (the chain is held cleared while Rst is high), running=0, done=0, busy=0.
  - Rst mid-operation aborts immediately, with no done pulse.
- States: IDLE, RUN, PAUSE, DONE. Command priority is clear > stop > start.
- IDLE:
  - cnt_rst_n=1, no ticks.
  - On cmd_start: capture limit into limit_r, set prescaler=0, go to RUN.
- RUN:
  - The prescaler increments each cycle. When prescaler==DIV-1, a tick occurs and the prescaler returns to 0.
  - On a tick, compare q_in to limit_r:
    - Not equal: cnt_cin=1 in the following cycle.
    - Equal: done=1 in the following cycle and cnt_cin stays 0 (no tick is issued past the limit).
      - auto_reload=1: cnt_rst_n=0 for exactly that one cycle and stay in RUN. The prescaler restarts from 0 and the next compare sees q_in=000.
      - auto_reload=0: go to DONE.
  - cmd_stop: go to PAUSE. The prescaler freezes and no tick is issued in that cycle.
- PAUSE:
  - Prescaler is held.
  - cmd_start resumes RUN from the held prescaler value. limit is NOT recaptured.
- DONE:
  - Count is held at the limit.
  - cmd_start: one-cycle clear pulse (cnt_rst_n=0), recapture limit, prescaler=0, go to RUN.
- cmd_clear in any non-reset state:
  - cnt_rst_n=0 for one cycle, prescaler=0, go to IDLE.
  - Clear wins over a simultaneous tick: no cnt_cin, no done.
- Simultaneous stop and tick: stop wins and the tick is discarded. The prescaler holds at DIV-1, so on resume the tick occurs in the first RUN cycle.
- cnt_cin and cnt_rst_n=0 are never asserted in the same cycle.
- Latency:
  - Tick decision to cnt_cin high: 1 cycle.
  - cnt_cin to updated q_in: 1 cycle.
  - Tick period: exactly DIV cycles in steady RUN.
- limit=000: the first tick after start produces done, and no count pulse is ever issued.
- Overflow handling: limit=999 with auto_reload=1 clears the chain via cnt_rst_n. The chain's carry-out is never relied upon.
- running and busy are decoded combinationally from the state register. done is registered.

Optional Feature:
- Macro: BCD_CTRL_LIMIT_CHECK_EN.
- When defined:
  - Adds output limit_err (1 bit, reset value 0).
  - On cmd_start in IDLE or DONE, if any nibble of limit is greater than 9, the FSM stays in (or enters) IDLE without starting or clearing.
  - limit_err is set and holds until the next valid start or cmd_clear.
- When undefined:
  - No limit_err port.
  - Any limit is accepted. A non-BCD limit is never matched, so the counter runs until clear or stop.

Test Plan:
1. DIV=4, limit=005, auto_reload=0, start → cnt_cin pulses every 4 cycles, 5 pulses total; q_in steps 000..005; done pulses once on the 6th tick; state DONE; running=0.
2. limit=003, auto_reload=1, run 10 ticks → pulse pattern inc,inc,inc,clear(done),… ; q_in cycles 000→003→000; done pulses on ticks 4 and 8.
3. Run to q_in=002, stop for 20 cycles, start → no cnt_cin during the pause, q_in holds 002; the first tick after resume occurs after the remaining prescaler count; limit unchanged even if the limit port changed during the pause.
4. cmd_clear coincident with a tick at q_in=007 → no cnt_cin, no done, cnt_rst_n low for 1 cycle, state IDLE, q_in=000.
5. Rst asserted in RUN at q_in=045 → next cycle all outputs are at reset values, cnt_rst_n=0; the chain stays cleared until Rst is deasserted.
6. BCD_CTRL_LIMIT_CHECK_EN defined, limit=0A1, start → limit_err=1, state IDLE, no cnt_cin; then limit=010, start → limit_err=0, counting begins.
